// File: rtl/mux_pkg.sv
// Shared encodings and sizing helpers for the mux select arbiter.
package mux_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    // Channel identifiers; also the value driven on the mux select line
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Width needed to hold 0..dwell-1, never narrower than one bit
    function automatic int cnt_w(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_select_arbiter_dwell_counter.sv
// Saturating dwell counter: counts cycles spent in a grant, stops at DWELL-1.
module dwell_counter
    import mux_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = cnt_w(DWELL)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    assign term_o = (cnt_q == LAST);

    // Clear has priority so a fresh grant always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter with minimum dwell that drives a 2:1 mux datapath.
module mux_select_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             select,
    output logic [WIDTH-1:0] I0,
    output logic [WIDTH-1:0] I1,
    output logic             valid
);

    localparam int CNT_W = cnt_w(DWELL);

    arb_state_e       state_q, state_d;
    logic             ptr_q;
    logic             gnt0_q, gnt1_q, select_q, valid_q;
    logic [WIDTH-1:0] i0_q, i1_q;
    logic             cnt_clr, cnt_en, dwell_done;

    dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (dwell_done)
    );

    // Next-state: a holder keeps the grant until it drops or, when the
    // other side waits, until the dwell expires
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = (ptr_q == CH0) ? GRANT0 : GRANT1;
                else if (req0)     state_d = GRANT0;
                else if (req1)     state_d = GRANT1;
            end
            GRANT0: begin
                if (!req0)                  state_d = req1 ? GRANT1 : IDLE;
                else if (req1 && dwell_done) state_d = GRANT1;
            end
            GRANT1: begin
                if (!req1)                  state_d = req0 ? GRANT0 : IDLE;
                else if (req0 && dwell_done) state_d = GRANT0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every grant entry and runs while any grant is held
    assign cnt_clr = (state_d != IDLE) && (state_d != state_q);
    assign cnt_en  = (state_q != IDLE);

    // FSM state, registered grant/select outputs and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            select_q <= CH0;
            ptr_q    <= CH0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= (state_d == GRANT0);
            gnt1_q  <= (state_d == GRANT1);
            // select only moves on a grant; IDLE keeps the last channel
            if (state_d == GRANT0) select_q <= CH0;
            if (state_d == GRANT1) select_q <= CH1;
            // Leaving a grant hands tie priority to the channel not just served
            if (state_q != IDLE && state_d != state_q)
                ptr_q <= (state_q == GRANT0) ? CH1 : CH0;
        end
    end

    // Capture granted data; valid lines up with the captured word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i0_q    <= '0;
            i1_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            if (gnt0_q) i0_q <= d0;
            if (gnt1_q) i1_q <= d1;
            valid_q <= gnt0_q | gnt1_q;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign select = select_q;
    assign I0     = i0_q;
    assign I1     = i1_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter (DWELL=4 main instance, DWELL=1 sweep).
module tb_mux_select_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] d0, d1;

    logic       gnt0, gnt1, select, valid;
    logic [7:0] I0, I1;
    logic       s_gnt0, s_gnt1, s_select, s_valid;
    logic [7:0] s_I0, s_I1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Tie pattern for DWELL=4 over edges 1..9: four cycles each side
    logic [0:8] tie_g0 = 9'b111100001;

    // DWELL=1 sweep expectations per step
    logic [0:5] sw_g0 = 6'b101010;
    logic [0:5] sw_vl = 6'b011111;
    logic [7:0] sw_i0 [6] = '{8'h00, 8'h11, 8'h11, 8'h13, 8'h13, 8'h15};
    logic [7:0] sw_i1 [6] = '{8'h00, 8'h00, 8'h22, 8'h22, 8'h24, 8'h24};

    always #5 clk = ~clk;

    mux_select_arbiter #(.WIDTH(8), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .select(select), .I0(I0), .I1(I1), .valid(valid)
    );

    mux_select_arbiter #(.WIDTH(8), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .select(s_select), .I0(s_I0), .I1(s_I1), .valid(s_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        req1 = 1'b1; d1 = 8'h3C;
        tick();
        tick();
        total_cnt++;
        if ({gnt1, select, valid, I1} !== {1'b1, 1'b1, 1'b1, 8'h3C})
            $display("FAIL pre_reset_grant got=%b%b%b/%h exp=111/3c", gnt1, select, valid, I1);
        else pass_cnt++;
        // Reset mid-cycle, no clock edge before sampling
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({gnt0, gnt1, select, valid} !== 4'b0000)
            $display("FAIL async_reset_ctrl got=%b%b%b%b exp=0000", gnt0, gnt1, select, valid);
        else pass_cnt++;
        total_cnt++;
        if ({I0, I1} !== 16'h0000)
            $display("FAIL async_reset_data got=%h/%h exp=00/00", I0, I1);
        else pass_cnt++;
        // Held through an edge with requests active
        req0 = 1'b1;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, valid} !== 3'b000)
            $display("FAIL reset_held got=%b%b%b exp=000", gnt0, gnt1, valid);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        // Tie right after reset goes to channel 0
        tick();
        total_cnt++;
        if ({gnt0, gnt1, select} !== 3'b100)
            $display("FAIL reset_restart_prio got=%b%b%b exp=100", gnt0, gnt1, select);
        else pass_cnt++;
    endtask

    task automatic test_single_channel();
        apply_reset();
        req1 = 1'b1; d1 = 8'hA5;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, select, valid} !== 4'b0110)
            $display("FAIL single_grant got=%b%b%b%b exp=0110", gnt0, gnt1, select, valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, valid, I1} !== {3'b011, 8'hA5})
            $display("FAIL single_data got=%b%b%b/%h exp=011/a5", gnt0, gnt1, valid, I1);
        else pass_cnt++;
        total_cnt++;
        if (I0 !== 8'h00)
            $display("FAIL single_i0_untouched got=%h exp=00", I0);
        else pass_cnt++;
    endtask

    task automatic test_tie_dwell();
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            total_cnt++;
            if ({gnt0, gnt1, select} !== {tie_g0[i], ~tie_g0[i], ~tie_g0[i]})
                $display("FAIL tie_edge%0d got=%b%b%b exp=%b%b%b", i + 1, gnt0, gnt1, select,
                         tie_g0[i], ~tie_g0[i], ~tie_g0[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        req0 = 1'b1; d0 = 8'h11;
        tick();
        req1 = 1'b1;
        tick();
        total_cnt++;
        if ({gnt0, gnt1} !== 2'b10)
            $display("FAIL early_hold got=%b%b exp=10", gnt0, gnt1);
        else pass_cnt++;
        req0 = 1'b0;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, select} !== 3'b011)
            $display("FAIL early_switch got=%b%b%b exp=011", gnt0, gnt1, select);
        else pass_cnt++;
        // Fresh dwell: GRANT1 must last a full four cycles against req0
        req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({gnt0, gnt1} !== 2'b01)
                $display("FAIL early_dwell%0d got=%b%b exp=01", i, gnt0, gnt1);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({gnt0, gnt1, select} !== 3'b100)
            $display("FAIL early_back got=%b%b%b exp=100", gnt0, gnt1, select);
        else pass_cnt++;
    endtask

    task automatic test_idle_hold();
        apply_reset();
        req1 = 1'b1; d1 = 8'h5A;
        tick();
        tick();
        req1 = 1'b0; d1 = 8'h3C;
        tick();
        total_cnt++;
        if ({gnt0, gnt1, select, valid, I1} !== {4'b0011, 8'h3C})
            $display("FAIL idle_enter got=%b%b%b%b/%h exp=0011/3c", gnt0, gnt1, select, valid, I1);
        else pass_cnt++;
        d1 = 8'hFF;
        tick();
        total_cnt++;
        if ({gnt1, select, valid, I1} !== {3'b010, 8'h3C})
            $display("FAIL idle_hold got=%b%b%b/%h exp=010/3c", gnt1, select, valid, I1);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({select, valid, I1} !== {2'b10, 8'h3C})
            $display("FAIL idle_stay got=%b%b/%h exp=10/3c", select, valid, I1);
        else pass_cnt++;
    endtask

    task automatic test_dwell1_sweep();
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d0 = 8'h10 + 8'(i);
            d1 = 8'h20 + 8'(i);
            tick();
            total_cnt++;
            if ({s_gnt0, s_gnt1, s_select, s_valid} !== {sw_g0[i], ~sw_g0[i], ~sw_g0[i], sw_vl[i]})
                $display("FAIL sweep_ctrl%0d got=%b%b%b%b exp=%b%b%b%b", i, s_gnt0, s_gnt1, s_select,
                         s_valid, sw_g0[i], ~sw_g0[i], ~sw_g0[i], sw_vl[i]);
            else pass_cnt++;
            total_cnt++;
            if ({s_I0, s_I1} !== {sw_i0[i], sw_i1[i]})
                $display("FAIL sweep_data%0d got=%h/%h exp=%h/%h", i, s_I0, s_I1, sw_i0[i], sw_i1[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_tie_dwell();
        test_early_release();
        test_idle_hold();
        test_dwell1_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
- Upstream stage that drives the team's 2:1 mux (inputs I0, I1, select; output Y).
- Arbitrates between two requesting sources using round-robin with a minimum dwell time.
- Drives the mux `select` line and registered copies of each source's data onto the mux I0/I1 inputs.
- Turns the mux from a hand-driven combinational block into a time-shared datapath.

Parameters:
- WIDTH, 8: data width of each channel and of the mux inputs.
- DWELL, 4: minimum cycles a grant is held while the other channel is waiting; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0  input  1  channel 0 requests the mux
- req1  input  1  channel 1 requests the mux
- d0  input  WIDTH  channel 0 data
- d1  input  WIDTH  channel 1 data
- gnt0  output  1  channel 0 granted (registered)
- gnt1  output  1  channel 1 granted (registered)
- select  output  1  mux select: 0 = I0, 1 = I1 (registered)
- I0  output  WIDTH  registered channel 0 data to the mux
- I1  output  WIDTH  registered channel 1 data to the mux
- valid  output  1  mux output Y carries granted data this cycle

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values while rst=1, applied immediately and independent of clk:
  - state=IDLE, gnt0=gnt1=0, select=0, I0=I1=0, valid=0
  - dwell count=0, round-robin pointer=0 (channel 0 has priority on the first tie)
- States: IDLE, GRANT0, GRANT1. In GRANTn: gntn=1, select=n. gnt0 and gnt1 are never both 1.
- IDLE transitions:
  - req0 & req1 -> GRANTp, where p = pointer.
  - Only one req -> grant that channel.
  - No req -> stay in IDLE; select holds its last value.
- GRANTn transitions (m = the other channel):
  - reqn=0 and reqm=1 -> GRANTm.
  - reqn=0 and reqm=0 -> IDLE.
  - reqn=1, reqm=1, count==DWELL-1 -> GRANTm.
  - Otherwise stay in GRANTn.
- Dwell counter:
  - Cleared on every entry to a GRANT state.
  - Increments each cycle in GRANT, saturates at DWELL-1.
  - With DWELL=1, both channels requesting alternates grants every cycle.
- Pointer update: on any transition out of GRANTn, pointer <= m (the channel not just served).
- Grant latency: req sampled at edge k -> gnt/select updated at edge k+1.
- Data capture:
  - At each edge where gnt0=1, I0 <= d0; at each edge where gnt1=1, I1 <= d1.
  - Non-granted I register holds its value.
- valid <= gnt0|gnt1, i.e. valid lags gnt by one cycle and is aligned with captured data. Hence Y = d(select) captured one cycle after grant.
- Simultaneous events:
  - Current requester drops exactly as dwell expires -> same result as the drop rule (switch or IDLE).
  - Request reasserted in the same cycle the grant is released -> not re-granted that cycle.
- Reset mid-grant: all state and outputs return to reset values asynchronously; arbitration restarts from IDLE with channel 0 priority.
- No combinational path from inputs to any output.

Decomposition:
- Shared package mux_pkg:
  - state encoding constants: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2
  - channel constants: CH0=1'b0, CH1=1'b1
  - counter width: CNT_W derived from DWELL, minimum 1
- One sub-module, dwell_counter: clear, enable, saturating at DWELL-1, terminal flag output.
- Arbiter FSM, pointer and data registers live in mux_select_arbiter.

Test Plan:
- Reset check: assert rst mid-cycle with req0=1 -> gnt0=0, select=0, I0=I1=8'h00, valid=0 without waiting for a clk edge.
- Single channel: req1=1, d1=8'hA5 from edge 0 -> gnt1=1 and select=1 at edge 1; I1=8'hA5 and valid=1 at edge 2; gnt0 stays 0.
- Tie after reset: req0=req1=1 at edge 0, DWELL=4 -> GRANT0 for exactly 4 cycles (edges 1-4), then GRANT1 for 4 cycles, then GRANT0 again; select toggles every 4 cycles.
- Early release: GRANT0 with count=1 and req1=1; drop req0 -> gnt1=1 at the next edge, count restarts at 0.
- Idle hold: GRANT1 active, drop req1 with req0=0 -> IDLE, gnt1=0, valid=0 one edge later; select stays 1 and I1 holds its last value.
- DWELL=1 sweep: req0=req1=1 held for 6 cycles -> gnt alternates 0,1,0,1,0,1; I0/I1 capture alternately; no overlap of gnt0/gnt1.
